// File: rtl/sum_loader_pkg.sv
// Shared types and constants for the sum_array_loader slice.
// The one-hot state encoding follows the Sum engine's one-hot style.
package sum_loader_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_MAX_N  = 1024;
  localparam int LEN_W      = 32;

  localparam logic [4:0] ONEHOT_IDLE = 5'b00001;
  localparam logic [4:0] ONEHOT_LOAD = 5'b00010;
  localparam logic [4:0] ONEHOT_KICK = 5'b00100;
  localparam logic [4:0] ONEHOT_WAIT = 5'b01000;
  localparam logic [4:0] ONEHOT_DONE = 5'b10000;

  typedef enum logic [4:0] {
    ST_IDLE = ONEHOT_IDLE,
    ST_LOAD = ONEHOT_LOAD,
    ST_KICK = ONEHOT_KICK,
    ST_WAIT = ONEHOT_WAIT,
    ST_DONE = ONEHOT_DONE
  } loader_state_t;

  // Limits a requested element count to the array depth.
  function automatic logic [LEN_W-1:0] loader_clamp_len(
    input logic [LEN_W-1:0] i_n,
    input logic [LEN_W-1:0] i_max
  );
    return (i_n > i_max) ? i_max : i_n;
  endfunction

endpackage

// File: rtl/loader_wr_port.sv
// Registered single-port write interface for array a: a beat strobe and an
// index become one memory write on the following cycle.
module loader_wr_port
  import sum_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_beat,
  input  logic [ADDR_W-1:0] i_idx,
  input  logic [DATA_W-1:0] i_data,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_ce,
  output logic              o_we
);

  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_data;
  logic              r_ce;
  logic              r_we;

  // Address and data hold their last value between writes; only the strobes pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_address <= '0;
      r_data    <= '0;
      r_ce      <= 1'b0;
      r_we      <= 1'b0;
    end else begin
      r_ce <= i_beat;
      r_we <= i_beat;
      if (i_beat) begin
        r_address <= i_idx;
        r_data    <= i_data;
      end
    end
  end

  assign o_address = r_address;
  assign o_data    = r_data;
  assign o_ce      = r_ce;
  assign o_we      = r_we;

endmodule

// File: rtl/sum_array_loader.sv
// Streams n words into array a, then resets, starts and waits on the Sum engine.
// Optional build macro LOADER_CLAMP_EN limits the element count to MAX_N.
module sum_array_loader
  import sum_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MAX_N  = DEF_MAX_N
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_done,
  input  logic [LEN_W-1:0]  n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] a_address0,
  output logic [DATA_W-1:0] a_d0,
  output logic              a_ce0,
  output logic              a_we0,
  output logic [LEN_W-1:0]  sum_n,
  output logic              sum_rst_n,
  output logic              sum_start,
  input  logic              sum_done,
  input  logic [DATA_W-1:0] sum_return,
  output logic [DATA_W-1:0] result,
  output logic              clamped
);

  loader_state_t     r_state;
  loader_state_t     w_nextState;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_idx;
  logic [LEN_W-1:0]  w_capLen;
  logic              w_capClamp;
  logic              w_startAcc;
  logic              w_beat;
  logic              w_lastBeat;
  logic              r_sReady;
  logic              r_apIdle;
  logic              r_apDone;
  logic              r_sumStart;
  logic              r_sumRstN;
  logic              r_clamped;
  logic [DATA_W-1:0] r_result;

`ifdef LOADER_CLAMP_EN
  assign w_capLen   = loader_clamp_len(n, LEN_W'(MAX_N));
  assign w_capClamp = (n > LEN_W'(MAX_N));
`else
  assign w_capLen   = n;
  assign w_capClamp = 1'b0;
`endif

  // s_ready is high exactly while in LOAD, so it doubles as the load-phase qualifier.
  assign w_startAcc = (r_state == ST_IDLE) && ap_start;
  assign w_beat     = s_valid && r_sReady;
  assign w_lastBeat = w_beat && (r_idx == (r_len - LEN_W'(1)));

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (ap_start) begin
          w_nextState = (w_capLen != '0) ? ST_LOAD : ST_KICK;
        end
      end
      ST_LOAD: begin
        if (w_lastBeat) begin
          w_nextState = ST_KICK;
        end
      end
      ST_KICK: w_nextState = ST_WAIT;
      ST_WAIT: begin
        if (sum_done) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state so they arrive registered
  // in the same cycle the state does.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_apIdle   <= 1'b1;
      r_apDone   <= 1'b0;
      r_sReady   <= 1'b0;
      r_sumStart <= 1'b0;
      r_sumRstN  <= 1'b0;
    end else begin
      r_apIdle   <= (w_nextState == ST_IDLE);
      r_apDone   <= (w_nextState == ST_DONE);
      r_sReady   <= (w_nextState == ST_LOAD);
      r_sumStart <= (w_nextState == ST_WAIT);
      r_sumRstN  <= (w_nextState != ST_KICK);
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_len     <= '0;
      r_idx     <= '0;
      r_clamped <= 1'b0;
      r_result  <= '0;
    end else begin
      if (w_startAcc) begin
        r_len     <= w_capLen;
        r_idx     <= '0;
        r_clamped <= w_capClamp;
      end else if (w_beat) begin
        r_idx <= r_idx + LEN_W'(1);
      end
      if ((r_state == ST_WAIT) && sum_done) begin
        r_result <= sum_return;
      end
    end
  end

  loader_wr_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_wr_port (
    .i_clk     (ap_clk),
    .i_rst     (ap_rst),
    .i_beat    (w_beat),
    .i_idx     (ADDR_W'(r_idx)),
    .i_data    (s_data),
    .o_address (a_address0),
    .o_data    (a_d0),
    .o_ce      (a_ce0),
    .o_we      (a_we0)
  );

  assign ap_idle   = r_apIdle;
  assign ap_done   = r_apDone;
  assign s_ready   = r_sReady;
  assign sum_n     = r_len;
  assign sum_rst_n = r_sumRstN;
  assign sum_start = r_sumStart;
  assign result    = r_result;
  assign clamped   = r_clamped;

endmodule

// File: tb/tb_sum_array_loader.sv
// Bench for sum_array_loader: a behavioural Sum engine plus a per-cycle
// reference model of the loader's visible behaviour.
module tb_sum_array_loader;

  localparam int TB_MAX_N = 8;

  logic        ap_clk;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_idle;
  logic        ap_done;
  logic [31:0] n;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] a_address0;
  logic [31:0] a_d0;
  logic        a_ce0;
  logic        a_we0;
  logic [31:0] sum_n;
  logic        sum_rst_n;
  logic        sum_start;
  logic        sum_done;
  logic [31:0] sum_return;
  logic [31:0] result;
  logic        clamped;

  sum_array_loader #(
    .DATA_W(32),
    .ADDR_W(32),
    .MAX_N (TB_MAX_N)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ap_start  (ap_start),
    .ap_idle   (ap_idle),
    .ap_done   (ap_done),
    .n         (n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .a_address0(a_address0),
    .a_d0      (a_d0),
    .a_ce0     (a_ce0),
    .a_we0     (a_we0),
    .sum_n     (sum_n),
    .sum_rst_n (sum_rst_n),
    .sum_start (sum_start),
    .sum_done  (sum_done),
    .sum_return(sum_return),
    .result    (result),
    .clamped   (clamped)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expLenOf(input logic [31:0] reqN);
`ifdef LOADER_CLAMP_EN
    return (reqN > 32'(TB_MAX_N)) ? 32'(TB_MAX_N) : reqN;
`else
    return reqN;
`endif
  endfunction

  function automatic logic expClampOf(input logic [31:0] reqN);
`ifdef LOADER_CLAMP_EN
    return reqN > 32'(TB_MAX_N);
`else
    return (reqN != reqN);
`endif
  endfunction

  // Behavioural Sum engine: sticky done, cleared by its active-low reset.
  logic [31:0] mem [64];
  logic [31:0] sumSalt = 0;
  int          sumLat  = 2;
  int          sumCnt  = 0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
  end

  always @(posedge ap_clk) begin
    if (a_ce0 && a_we0) mem[a_address0[5:0]] = a_d0;
  end

  always begin
    logic        rN;
    logic        st;
    logic [31:0] nn;
    logic [31:0] acc;
    @(posedge ap_clk);
    rN = sum_rst_n;
    st = sum_start;
    nn = sum_n;
    #1;
    if (rN !== 1'b1) begin
      sum_done = 1'b0;
      sumCnt   = 0;
    end else if (st && !sum_done) begin
      sumCnt++;
      if (sumCnt >= sumLat) begin
        acc = sumSalt;
        for (int i = 0; i < 64; i++) if (i < int'(nn)) acc += mem[i];
        sum_return = acc;
        sum_done   = 1'b1;
      end
    end
    if (!sum_done) sum_return = $urandom;
  end

  // Reference model of run progress; phases are the loader's externally visible run stages.
  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_KICK = 2;
  localparam int P_WAIT = 3;
  localparam int P_DONE = 4;

  int          mPhase = P_IDLE;
  logic [31:0] mLen   = 0;
  logic [31:0] mIdx   = 0;
  bit          mValid = 0;
  logic        eIdle, eDone, eSReady, eCe, eStart, eRstN, eClamped;
  logic [31:0] eAddr, eD, eResult;

  always @(posedge ap_clk) begin
    bit beat;
    if (ap_rst) begin
      mPhase = P_IDLE; mLen = 0; mIdx = 0; mValid = 1;
      eCe = 0; eAddr = 0; eD = 0; eResult = 0; eClamped = 0;
    end else begin
      beat = (mPhase == P_LOAD) && s_valid;
      eCe  = beat;
      if (beat) begin
        eAddr = mIdx;
        eD    = s_data;
        mIdx  = mIdx + 1;
      end
      case (mPhase)
        P_IDLE: if (ap_start) begin
          mLen     = expLenOf(n);
          eClamped = expClampOf(n);
          mIdx     = 0;
          mPhase   = (mLen != 0) ? P_LOAD : P_KICK;
        end
        P_LOAD: if (beat && mIdx == mLen) mPhase = P_KICK;
        P_KICK: mPhase = P_WAIT;
        P_WAIT: if (sum_done) begin
          eResult = sum_return;
          mPhase  = P_DONE;
        end
        default: mPhase = P_IDLE;
      endcase
    end
    eIdle   = (mPhase == P_IDLE);
    eDone   = !ap_rst && (mPhase == P_DONE);
    eSReady = !ap_rst && (mPhase == P_LOAD);
    eStart  = !ap_rst && (mPhase == P_WAIT);
    eRstN   = !ap_rst && (mPhase != P_KICK);
  end

  // Single compare process, run on the falling edge once reset has been seen.
  bit cmpOn     = 1;
  int wrCount   = 0;
  int doneCount = 0;
  int readyCnt  = 0;

  always @(negedge ap_clk) begin
    if (mValid && cmpOn) begin
      checkOutput("ap_idle",   ap_idle,   eIdle);
      checkOutput("ap_done",   ap_done,   eDone);
      checkOutput("s_ready",   s_ready,   eSReady);
      checkOutput("a_ce0",     a_ce0,     eCe);
      checkOutput("a_we0",     a_we0,     eCe);
      checkOutput("sum_n",     sum_n,     mLen);
      checkOutput("sum_rst_n", sum_rst_n, eRstN);
      checkOutput("sum_start", sum_start, eStart);
      checkOutput("result",    result,    eResult);
      checkOutput("clamped",   clamped,   eClamped);
      if (eCe) begin
        checkOutput("a_address0", a_address0, eAddr);
        checkOutput("a_d0",       a_d0,       eD);
      end
      if (a_ce0 && a_we0) wrCount++;
      if (ap_done) doneCount++;
      if (s_ready) readyCnt++;
    end
  end

  // One full run: vMode 0=valid held, 1=toggling, 2=random; dMode 0=1,2,3.. else random.
  task automatic applyStimulus(input logic [31:0] reqN, input int vMode, input int dMode,
                               input logic [31:0] salt, output logic [31:0] expRes);
    int          beats;
    logic [31:0] expSum;
    bit          gotDone;
    bit          acc;
    logic [31:0] expLen;
    expLen    = expLenOf(reqN);
    sumSalt   = salt;
    sumLat    = $urandom_range(1, 4);
    wrCount   = 0;
    doneCount = 0;
    readyCnt  = 0;
    beats     = 0;
    expSum    = 0;
    gotDone   = 0;
    s_data    = (dMode == 0) ? 32'd1 : $urandom;
    ap_start  = 1'b1;
    n         = reqN;
    @(posedge ap_clk); #1;
    ap_start  = 1'b0;
    n         = $urandom;
    for (int c = 0; c < 400 && !gotDone; c++) begin
      case (vMode)
        0:       s_valid = 1'b1;
        1:       s_valid = (c % 2 == 0);
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      @(negedge ap_clk);
      acc = s_valid && s_ready;
      if (acc) begin
        beats++;
        expSum += s_data;
      end
      if (ap_done) gotDone = 1;
      @(posedge ap_clk); #1;
      if (acc) s_data = (dMode == 0) ? 32'(beats + 1) : $urandom;
    end
    s_valid = 1'b0;
    checkOutput("run_completed", gotDone, 1'b1);
    repeat (2) begin
      @(posedge ap_clk); #1;
    end
    expRes = expSum + salt;
    checkOutput("beats_accepted", beats, expLen);
    checkOutput("write_count", wrCount, expLen);
    checkOutput("done_pulses", doneCount, 1);
    checkOutput("run_result", result, expRes);
  endtask

  initial begin
    logic [31:0] r;
    ap_rst = 1'b1; ap_start = 1'b0; n = '0; s_valid = 1'b0; s_data = '0;
    sum_done = 1'b0; sum_return = '0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    checkOutput("reset_idle",   ap_idle,   1'b1);
    checkOutput("reset_done",   ap_done,   1'b0);
    checkOutput("reset_ce",     a_ce0,     1'b0);
    checkOutput("reset_sum_n",  sum_n,     32'd0);
    checkOutput("reset_result", result,    32'd0);
    checkOutput("reset_rstn",   sum_rst_n, 1'b0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    checkOutput("post_reset_rstn", sum_rst_n, 1'b1);

    $display("[TB] n=4 sequential beats");
    applyStimulus(32'd4, 0, 0, 32'd0, r);
    checkOutput("n4_result_literal", result, 32'd10);

    $display("[TB] n=3 toggling valid");
    applyStimulus(32'd3, 1, 1, 32'h0000_0100, r);

    $display("[TB] n=0 run");
    applyStimulus(32'd0, 0, 1, 32'h0000_1234, r);
    checkOutput("n0_no_ready", readyCnt, 0);
    checkOutput("n0_result_literal", result, 32'h0000_1234);

    $display("[TB] start while busy, then reset mid-load");
    sumSalt = 0;
    s_valid = 1'b1; s_data = $urandom;
    ap_start = 1'b1; n = 32'd6;
    @(posedge ap_clk); #1;
    n = 32'd2; s_data = $urandom;
    @(posedge ap_clk); #1;
    ap_start = 1'b0; ap_rst = 1'b1; s_data = $urandom;
    @(negedge ap_clk);
    checkOutput("busy_start_sum_n", sum_n, 32'd6);
    @(posedge ap_clk);
    @(negedge ap_clk);
    checkOutput("midrst_idle",  ap_idle,   1'b1);
    checkOutput("midrst_ce",    a_ce0,     1'b0);
    checkOutput("midrst_start", sum_start, 1'b0);
    checkOutput("midrst_rstn",  sum_rst_n, 1'b0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0; s_valid = 1'b0;
    repeat (2) begin
      @(posedge ap_clk); #1;
    end
    checkOutput("after_rst_idle", ap_idle, 1'b1);
    applyStimulus(32'd5, 2, 1, $urandom, r);

    $display("[TB] n=20 clamp check");
    applyStimulus(32'd20, 0, 1, 32'd7, r);
`ifdef LOADER_CLAMP_EN
    checkOutput("n20_sum_n",   sum_n,   32'd8);
    checkOutput("n20_clamped", clamped, 1'b1);
`else
    checkOutput("n20_sum_n",   sum_n,   32'd20);
    checkOutput("n20_clamped", clamped, 1'b0);
`endif

    $display("[TB] randomized runs");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(32'($urandom_range(0, 12)), 2, 1, $urandom, r);
    end

    cmpOn = 0;
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
